// File: rtl/alu_operand_stage.sv
// Issue / operand-fetch / writeback stage around the BEAN ALU: regfile, E and W pipeline, RAW stall.
// Optional macro ALU_BYPASS_EN: forward the W-stage ALU result into the operand mux instead of stalling.
module alu_operand_stage #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_iss_valid,
  output logic            o_iss_ready,
  input  logic [4:0]      i_iss_op,
  input  logic [AW-1:0]   i_iss_rs1_addr,
  input  logic [AW-1:0]   i_iss_rs2_addr,
  input  logic [AW-1:0]   i_iss_rd_addr,
  output logic [4:0]      o_alu_op,
  output logic [XLEN-1:0] o_alu_rs1,
  output logic [XLEN-1:0] o_alu_rs2,
  output logic            o_alu_enable,
  input  logic [XLEN-1:0] i_alu_rd,
  output logic            o_wb_valid,
  output logic [AW-1:0]   o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  input  logic            i_dbg_we,
  input  logic [AW-1:0]   i_dbg_addr,
  input  logic [XLEN-1:0] i_dbg_wdata,
  output logic [XLEN-1:0] o_dbg_rdata
);
  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] r_rf [NREG];
  logic            r_e_vld, r_w_vld;
  logic [AW-1:0]   r_e_rd, r_w_rd;

  logic            w_e_hit1, w_e_hit2, w_w_hit1, w_w_hit2;
  logic            w_stall, w_accept, w_wb_we, w_dbg_we;
  logic [XLEN-1:0] w_rs1, w_rs2;

  // A producer with rd=x0 never creates a dependency, nor does a source of x0.
  assign w_e_hit1 = r_e_vld && (r_e_rd != '0) && (i_iss_rs1_addr == r_e_rd);
  assign w_e_hit2 = r_e_vld && (r_e_rd != '0) && (i_iss_rs2_addr == r_e_rd);
  assign w_w_hit1 = r_w_vld && (r_w_rd != '0) && (i_iss_rs1_addr == r_w_rd);
  assign w_w_hit2 = r_w_vld && (r_w_rd != '0) && (i_iss_rs2_addr == r_w_rd);

  always_comb begin
    w_rs1 = r_rf[i_iss_rs1_addr];
    w_rs2 = r_rf[i_iss_rs2_addr];
`ifdef ALU_BYPASS_EN
    w_stall = w_e_hit1 || w_e_hit2;
    if (w_w_hit1) w_rs1 = i_alu_rd;
    if (w_w_hit2) w_rs2 = i_alu_rd;
`else
    w_stall = w_e_hit1 || w_e_hit2 || w_w_hit1 || w_w_hit2;
`endif
  end

  assign o_iss_ready = !i_rst && !w_stall;
  assign w_accept    = i_iss_valid && o_iss_ready;
  assign w_wb_we     = r_w_vld && (r_w_rd != '0);
  // On a same-address collision the writeback owns the register.
  assign w_dbg_we    = i_dbg_we && (i_dbg_addr != '0) && !(w_wb_we && (r_w_rd == i_dbg_addr));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_e_vld   <= 1'b0;
      r_e_rd    <= '0;
      r_w_vld   <= 1'b0;
      r_w_rd    <= '0;
      o_alu_op  <= '0;
      o_alu_rs1 <= '0;
      o_alu_rs2 <= '0;
    end else begin
      r_e_vld <= w_accept;
      r_w_vld <= r_e_vld;
      r_w_rd  <= r_e_rd;
      if (w_accept) begin
        r_e_rd    <= i_iss_rd_addr;
        o_alu_op  <= i_iss_op;
        o_alu_rs1 <= w_rs1;
        o_alu_rs2 <= w_rs2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (w_dbg_we) r_rf[i_dbg_addr] <= i_dbg_wdata;
      if (w_wb_we)  r_rf[r_w_rd]     <= i_alu_rd;
    end
  end

  assign o_alu_enable = r_e_vld;
  assign o_wb_valid   = r_w_vld;
  assign o_wb_addr    = r_w_rd;
  assign o_wb_data    = r_w_vld ? i_alu_rd : '0;
  assign o_dbg_rdata  = r_rf[i_dbg_addr];
endmodule
